// File: rtl/mem_port_arbiter_if.sv
// Bus bundle for mem_port_arbiter: IF fetch port, DM data port, SRAM macro port.
// slave = arbiter side, master = CPU requesters plus SRAM macro.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;

  logic              dm_req;
  logic              dm_web;
  logic [DATA_W-1:0] dm_bweb;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic              dm_gnt;
  logic              dm_rvalid;
  logic [DATA_W-1:0] dm_rdata;

  logic              sram_ceb;
  logic              sram_web;
  logic [DATA_W-1:0] sram_bweb;
  logic [ADDR_W-1:0] sram_a;
  logic [DATA_W-1:0] sram_di;
  logic [DATA_W-1:0] sram_do;

  modport slave (
    input  if_req, if_addr,
    input  dm_req, dm_web, dm_bweb, dm_addr, dm_wdata,
    input  sram_do,
    output if_gnt, if_rvalid, if_rdata,
    output dm_gnt, dm_rvalid, dm_rdata,
    output sram_ceb, sram_web, sram_bweb, sram_a, sram_di
  );

  modport master (
    output if_req, if_addr,
    output dm_req, dm_web, dm_bweb, dm_addr, dm_wdata,
    output sram_do,
    input  if_gnt, if_rvalid, if_rdata,
    input  dm_gnt, dm_rvalid, dm_rdata,
    input  sram_ceb, sram_web, sram_bweb, sram_a, sram_di
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Single-port SRAM arbiter between IF fetch and DM data; clk, rst (sync, low), bus.
// MEM_ARB_RR_EN selects round-robin tie-break; default is fixed DM-over-IF.
module mem_port_arbiter #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 1
) (
  input logic               clk,
  input logic               rst,
  mem_port_arbiter_if.slave bus
);

  typedef enum logic {
    IDLE,
    WAIT
  } state_t;

  state_t            state;
  logic [1:0]        cnt;
  logic              owner_dm;
  logic [RD_LAT-1:0] vld;
  logic [ADDR_W-1:0] a_q;
  logic [DATA_W-1:0] di_q;
  logic [DATA_W-1:0] if_cap;
  logic [DATA_W-1:0] dm_cap;

  logic elig;
  logic dm_pick;
  logic dm_win;
  logic if_win;
  logic rd_win;
  logic rv;
  logic if_rv;
  logic dm_rv;

`ifdef MEM_ARB_RR_EN
  logic last_if;
  assign dm_pick = bus.dm_req & (~bus.if_req | last_if);
`else
  assign dm_pick = bus.dm_req;
`endif

  // Grants are masked during reset so every output sits at its reset value.
  assign elig   = rst & (state == IDLE);
  assign dm_win = elig & dm_pick;
  assign if_win = elig & bus.if_req & ~dm_pick;
  assign rd_win = if_win | (dm_win & bus.dm_web);

  assign bus.dm_gnt = dm_win;
  assign bus.if_gnt = if_win;

  // One read in flight at a time, so a single owner tag is enough.
  assign rv    = rst & vld[RD_LAT-1];
  assign if_rv = rv & ~owner_dm;
  assign dm_rv = rv & owner_dm;

  assign bus.if_rvalid = if_rv;
  assign bus.dm_rvalid = dm_rv;
  assign bus.if_rdata  = !rst ? '0 : (if_rv ? bus.sram_do : if_cap);
  assign bus.dm_rdata  = !rst ? '0 : (dm_rv ? bus.sram_do : dm_cap);

  always_comb begin
    bus.sram_ceb  = 1'b1;
    bus.sram_web  = 1'b1;
    bus.sram_bweb = '1;
    bus.sram_a    = a_q;
    bus.sram_di   = di_q;
    unique case (1'b1)
      dm_win: begin
        bus.sram_ceb  = 1'b0;
        bus.sram_web  = bus.dm_web;
        bus.sram_bweb = bus.dm_bweb;
        bus.sram_a    = bus.dm_addr;
        bus.sram_di   = bus.dm_wdata;
      end
      if_win: begin
        bus.sram_ceb = 1'b0;
        bus.sram_a   = bus.if_addr;
      end
      default: ;
    endcase
    if (!rst) begin
      bus.sram_a  = '0;
      bus.sram_di = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      cnt      <= '0;
      owner_dm <= 1'b0;
      vld      <= '0;
      a_q      <= '0;
      di_q     <= '0;
      if_cap   <= '0;
      dm_cap   <= '0;
`ifdef MEM_ARB_RR_EN
      last_if  <= 1'b1;
`endif
    end else begin
      // Shift register: bit 0 takes the new read, top bit is rvalid.
      vld <= RD_LAT'({vld, rd_win});
      if (dm_win | if_win)
        a_q <= dm_win ? bus.dm_addr : bus.if_addr;
      if (dm_win)
        di_q <= bus.dm_wdata;
      if (rd_win)
        owner_dm <= dm_win;
      if (if_rv)
        if_cap <= bus.sram_do;
      if (dm_rv)
        dm_cap <= bus.sram_do;
`ifdef MEM_ARB_RR_EN
      if (dm_win | if_win)
        last_if <= if_win;
`endif
      case (state)
        IDLE: begin
          if (rd_win && RD_LAT > 1) begin
            state <= WAIT;
            cnt   <= 2'(RD_LAT - 1);
          end
        end
        WAIT: begin
          if (cnt == 2'd1) begin
            state <= IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt - 2'd1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter at RD_LAT 1, 2 and 3.
// Each instance has its own requesters and a transaction-level reference model.
module tb_mem_port_arbiter;

  localparam int AW   = 14;
  localparam int DW   = 32;
  localparam int NCYC = 2000;

  typedef struct {
    int due;
    bit dm;
  } resp_t;

  logic clk = 1'b0;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  for (genvar gi = 0; gi < 3; gi++) begin : g
    localparam int L = gi + 1;

    logic rst;

    mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    mem_port_arbiter #(
      .ADDR_W(AW),
      .DATA_W(DW),
      .RD_LAT(L)
    ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
    );

    initial begin : run
      resp_t          q[$];
      int             free_at;
      bit             m_last_if;
      logic [AW-1:0]  m_a;
      logic [DW-1:0]  m_di;
      logic [DW-1:0]  m_ifcap;
      logic [DW-1:0]  m_dmcap;
      bit             if_took;
      bit             dm_took;
      int             rlo;
      bit             run_on;
      bit             elig;
      bit             pick_dm;
      bit             e_dm;
      bit             e_if;
      bit             hit;
      bit             e_rvif;
      bit             e_rvdm;
      logic           e_web;
      logic [DW-1:0]  e_bweb;
      logic [AW-1:0]  e_a;
      logic [DW-1:0]  e_di;
      logic [DW-1:0]  e_ifd;
      logic [DW-1:0]  e_dmd;
      string          p;

      p         = $sformatf("L%0d", L);
      free_at   = 0;
      m_last_if = 1'b1;
      m_a       = '0;
      m_di      = '0;
      m_ifcap   = '0;
      m_dmcap   = '0;
      if_took   = 1'b0;
      dm_took   = 1'b0;
      rlo       = 0;

      rst          = 1'b0;
      bus.if_req   = 1'b0;
      bus.if_addr  = '0;
      bus.dm_req   = 1'b0;
      bus.dm_web   = 1'b1;
      bus.dm_bweb  = '1;
      bus.dm_addr  = '0;
      bus.dm_wdata = '0;
      bus.sram_do  = '0;

      for (int c = 0; c < NCYC; c++) begin
        @(posedge clk);
        #1;
        // occasional reset bursts, including mid-read
        if (c < 3) begin
          rst = 1'b0;
        end else if (rlo > 0) begin
          rst = 1'b0;
          rlo--;
        end else if ($urandom_range(0, 59) == 0) begin
          rst = 1'b0;
          rlo = $urandom_range(0, 3);
        end else begin
          rst = 1'b1;
        end

        // requesters hold until granted, then may issue anew
        if (!bus.if_req || if_took) begin
          bus.if_req  = ($urandom_range(0, 3) != 0);
          bus.if_addr = AW'($urandom);
        end
        if (!bus.dm_req || dm_took) begin
          bus.dm_req   = ($urandom_range(0, 3) != 0);
          bus.dm_web   = 1'($urandom_range(0, 1));
          bus.dm_bweb  = $urandom;
          bus.dm_addr  = AW'($urandom);
          bus.dm_wdata = $urandom;
        end
        bus.sram_do = $urandom;

        @(negedge clk);
        run_on = (rst === 1'b1);
        elig   = run_on && (c >= free_at);
`ifdef MEM_ARB_RR_EN
        pick_dm = bus.dm_req && (!bus.if_req || m_last_if);
`else
        pick_dm = bus.dm_req;
`endif
        e_dm   = elig && pick_dm;
        e_if   = elig && bus.if_req && !pick_dm;
        hit    = run_on && (q.size() > 0) && (q[0].due == c);
        e_rvdm = hit && q[0].dm;
        e_rvif = hit && !q[0].dm;

        e_web  = e_dm ? bus.dm_web : 1'b1;
        e_bweb = e_dm ? bus.dm_bweb : '1;
        if (!run_on)   e_a = '0;
        else if (e_dm) e_a = bus.dm_addr;
        else if (e_if) e_a = bus.if_addr;
        else           e_a = m_a;
        if (!run_on)   e_di = '0;
        else if (e_dm) e_di = bus.dm_wdata;
        else           e_di = m_di;
        e_ifd = !run_on ? '0 : (e_rvif ? bus.sram_do : m_ifcap);
        e_dmd = !run_on ? '0 : (e_rvdm ? bus.sram_do : m_dmcap);

        chk({p, " if_gnt"},    64'(bus.if_gnt),    64'(e_if));
        chk({p, " dm_gnt"},    64'(bus.dm_gnt),    64'(e_dm));
        chk({p, " sram_ceb"},  64'(bus.sram_ceb),  64'(!(e_dm || e_if)));
        chk({p, " sram_web"},  64'(bus.sram_web),  64'(e_web));
        chk({p, " sram_bweb"}, 64'(bus.sram_bweb), 64'(e_bweb));
        chk({p, " sram_a"},    64'(bus.sram_a),    64'(e_a));
        chk({p, " sram_di"},   64'(bus.sram_di),   64'(e_di));
        chk({p, " if_rvalid"}, 64'(bus.if_rvalid), 64'(e_rvif));
        chk({p, " dm_rvalid"}, 64'(bus.dm_rvalid), 64'(e_rvdm));
        chk({p, " if_rdata"},  64'(bus.if_rdata),  64'(e_ifd));
        chk({p, " dm_rdata"},  64'(bus.dm_rdata),  64'(e_dmd));

        // advance the model across the coming clock edge
        if (!run_on) begin
          q.delete();
          free_at   = c + 1;
          m_last_if = 1'b1;
          m_a       = '0;
          m_di      = '0;
          m_ifcap   = '0;
          m_dmcap   = '0;
        end else begin
          if (hit) begin
            if (q[0].dm) m_dmcap = bus.sram_do;
            else         m_ifcap = bus.sram_do;
            void'(q.pop_front());
          end
          if (e_dm || e_if) begin
            m_a       = e_a;
            m_last_if = e_if;
          end
          if (e_dm) m_di = bus.dm_wdata;
          if (e_if || (e_dm && bus.dm_web)) begin
            q.push_back('{due: c + L, dm: e_dm});
            free_at = c + L;
          end
        end
        if_took = e_if;
        dm_took = e_dm;
      end
    end
  end

  initial begin
    repeat (NCYC + 10) @(posedge clk);
    #2;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbitrates one single-port SRAM between the CPU's instruction-fetch requester (IF, read-only) and data-memory requester (MEM stage, read/write). It sequences every access, tracks the fixed SRAM read latency and routes read data back to the requester that issued the read. The pipeline uses the grant outputs as stall conditions. It sits between `CPU` and a unified instruction/data SRAM macro.

## Interface
- `ADDR_W`, 14: word-address width.
- `DATA_W`, 32: data width.
- `RD_LAT`, 1: SRAM read latency in cycles. Legal range is 1..4.

- `clk` in 1: single clock. All logic is on the rising edge.
- `rst` in 1: synchronous, active-low reset.
- `if_req` in 1: fetch read request.
- `if_addr` in ADDR_W: fetch word address.
- `if_gnt` out 1: fetch request accepted this cycle.
- `if_rvalid` out 1: fetch read data valid.
- `if_rdata` out DATA_W: fetch read data.
- `dm_req` in 1: data request.
- `dm_web` in 1: 0 = write, 1 = read.
- `dm_bweb` in DATA_W: active-low bit write enables.
- `dm_addr` in ADDR_W: data word address.
- `dm_wdata` in DATA_W: write data.
- `dm_gnt` out 1: data request accepted this cycle.
- `dm_rvalid` out 1: data read data valid.
- `dm_rdata` out DATA_W: data read data.
- `sram_ceb` out 1: active-low chip enable.
- `sram_web` out 1: active-low write enable.
- `sram_bweb` out DATA_W: active-low bit write enables.
- `sram_a` out ADDR_W: SRAM address.
- `sram_di` out DATA_W: SRAM write data.
- `sram_do` in DATA_W: SRAM read data, valid RD_LAT cycles after the access.

## Operation
- State machine:
  - Two states, IDLE and WAIT.
  - Internal registers: a pending owner tag (IF or DM), a latency counter, and an rvalid pipe.
- Grant eligibility: the block may grant a request only in IDLE. When eligible, grant is combinational from the request in the same cycle.
- SRAM drive in the grant cycle:
  - `sram_ceb`=0.
  - `sram_a`, `sram_web`, `sram_bweb` and `sram_di` are muxed from the winning requester.
  - IF requests always drive `sram_web`=1.
- SRAM drive when no grant: `sram_ceb`=1, `sram_web`=1, `sram_bweb`=all ones, address and data hold their last values.
- Priority (default): DM wins over IF when both request. IF is starvable under continuous DM traffic.
- Write grant:
  - The write completes in the grant cycle and produces no rvalid.
  - The state stays IDLE, so back-to-back writes are accepted every cycle.
- Read grant:
  - The owner tag is recorded.
  - If RD_LAT>1, the state goes to WAIT with the counter loaded to RD_LAT-1.
  - In WAIT the counter decrements each cycle. When it reaches 0 the state returns to IDLE.
- Response routing: in cycle t+RD_LAT after a read grant in cycle t, exactly one of `if_rvalid`/`dm_rvalid` pulses for one cycle, chosen by the owner tag.
- Read data:
  - `*_rdata` equals `sram_do` while that port's rvalid is high.
  - Otherwise `*_rdata` holds the last delivered value from an internal capture register.
- Requester rule:
  - Hold req, address, web, bweb and wdata stable until gnt.
  - A requester may present a new request in the cycle after gnt.
- A request that is not granted is not queued. The stall is visible as `req & ~gnt`.

## Timing
- Reset values:
  - `if_gnt`=`dm_gnt`=0.
  - `if_rvalid`=`dm_rvalid`=0.
  - `if_rdata`=`dm_rdata`=0.
  - `sram_ceb`=1, `sram_web`=1, `sram_bweb`=all ones, `sram_a`=0, `sram_di`=0.
  - State IDLE, counter 0.
- Read latency: RD_LAT cycles from grant to rvalid.
- Next grant after a read: allowed in cycle t+RD_LAT, the same cycle as rvalid.
  - With RD_LAT=1 the state never enters WAIT, giving one read per cycle.
  - With RD_LAT=N, reads are accepted at most once every N cycles.
- Write throughput: one write per cycle while IDLE. A write is never granted in WAIT.
- Simultaneous requests: only one gnt is high per cycle. The loser's gnt is 0 and it must hold its request.
- Reset mid-read: the pending read is discarded, no rvalid is produced after reset, and the counter clears.

## Configuration
- Macro: `MEM_ARB_RR_EN`.
- Defined: round-robin tie-break.
  - A 1-bit last-grant register updates on every grant.
  - On simultaneous requests, the requester not granted last wins.
  - Reset value is "IF last", so DM wins the first tie.
  - A lone request is always granted when eligible.
- Undefined: fixed DM-over-IF priority. The last-grant register is not present.

## Test plan
- Single IF read, RD_LAT=2, addr 0x0010, `sram_do`=0xDEADBEEF:
  - `if_gnt` high in cycle 0 with `sram_ceb`=0 and `sram_a`=0x0010.
  - `if_rvalid` pulses in cycle 2 with `if_rdata`=0xDEADBEEF, and `if_rdata` holds that value afterwards.
- IF and DM read requested together every cycle, RD_LAT=1, macro off: `dm_gnt` every cycle, `if_gnt` never.
- Same stimulus with `MEM_ARB_RR_EN`: grants alternate DM, IF, DM, IF, and each rvalid routes to the matching port.
- DM write (`dm_web`=0, `dm_bweb`=0xFFFF0000, wdata 0x12345678) three cycles back-to-back:
  - `dm_gnt` high for all three cycles.
  - `sram_web`=0 and `sram_bweb`=0xFFFF0000 on all three.
  - No rvalid.
- Read granted in cycle 0 with RD_LAT=3, then `rst`=0 in cycle 1:
  - No rvalid in cycles 2-4.
  - All outputs at their reset values.
  - A new IF request is granted in the first cycle after `rst` returns to 1.
- DM write request arrives during WAIT with RD_LAT=3: `dm_gnt`=0 until cycle 3, then `dm_gnt`=1 with `sram_web`=0.
